mmc1_serial_port: RTL

Upstream front end of the MMC1 register file: it captures CPU writes to $8000-$FFFF, assembles the 5-bit serial load sequence (D0, LSB first), and delivers one parallel register write per completed sequence to the mapper register/bank-decode stage. It also applies the D7 reset rule and ignores writes on consecutive M2 cycles, so downstream logic sees only clean, decoded register updates.

---
 rtl/mmc1_serial_port.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mmc1_serial_port.sv
// -----------------------------------------------------------------------------
// mmc1_serial_port
//
// Front end of the MMC1 register file. It captures CPU writes to $8000-$FFFF
// and assembles the serial load sequence, which is D0 sent LSB first. Each
// completed sequence becomes one parallel register write for the bank-decode
// stage. A write with D7 set aborts the sequence and raises LOAD_RST.
//
// All state changes on the falling edge of CPU_M2. nRESET is asynchronous
// and active-low.
//
// Optional feature (macro MMC1_CONSEC_FILTER_EN):
//   When this macro is defined, the block ignores a write cycle that directly
//   follows another write cycle. Only the first write of a back-to-back burst
//   counts. This handles RMW double writes such as INC $8000.
//   When the macro is undefined, every write cycle is accepted.
//
// Parameters:
//   SHIFT_LEN    serial writes per register update (MMC1 = 5, range 2..8)
//
// Ports:
//   CPU_M2       in   CPU phi2; state updates on its falling edge
//   nRESET       in   asynchronous active-low reset
//   nCPU_ROMSEL  in   low = access to $8000-$FFFF
//   nCPU_RW      in   low = write
//   CPU_A14/A13  in   register select; taken only from the completing write
//   CPU_D0       in   serial data bit
//   CPU_D7       in   load-reset bit
//   REG_WE       out  one-period pulse; REG_SEL/REG_DATA valid
//   REG_SEL      out  {A14,A13}: 0 control, 1 CHR0, 2 CHR1, 3 PRG
//   REG_DATA     out  assembled value; bit 0 is the first serial write
//   LOAD_RST     out  one-period pulse on an accepted D7=1 write
//   SHIFT_CNT    out  number of accepted bits currently held
// -----------------------------------------------------------------------------
module mmc1_serial_port #(
    parameter int SHIFT_LEN = 5
) (
    input  logic                 CPU_M2,
    input  logic                 nRESET,
    input  logic                 nCPU_ROMSEL,
    input  logic                 nCPU_RW,
    input  logic                 CPU_A14,
    input  logic                 CPU_A13,
    input  logic                 CPU_D0,
    input  logic                 CPU_D7,
    output logic                 REG_WE,
    output logic [1:0]           REG_SEL,
    output logic [SHIFT_LEN-1:0] REG_DATA,
    output logic                 LOAD_RST,
    output logic [2:0]           SHIFT_CNT
);

    typedef enum logic {
        EMPTY,
        FILLING
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(SHIFT_LEN - 1);

    state_t                 state_q, state_d;
    // The shift register holds only the bits still pending. The completing
    // write supplies the final MSB directly, so SHIFT_LEN-1 bits are enough.
    logic [SHIFT_LEN-2:0]   shift_q, shift_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic                   rst_q, rst_d;
    logic [1:0]             sel_q, sel_d;
    logic [SHIFT_LEN-1:0]   data_q, data_d;

    logic                   write_cyc;
    logic                   accept;
    logic [SHIFT_LEN-1:0]   shift_in;

    assign write_cyc = ~nCPU_ROMSEL & ~nCPU_RW;

`ifdef MMC1_CONSEC_FILTER_EN
    // This flag is set by any write cycle of the previous M2 period, whether
    // that write was accepted or not. As a result, every write after the
    // first one in a burst stays filtered.
    logic prev_wr_q;

    always_ff @(negedge CPU_M2 or negedge nRESET) begin
        if (!nRESET) begin
            prev_wr_q <= 1'b0;
        end else begin
            prev_wr_q <= write_cyc;
        end
    end

    assign accept = write_cyc & ~prev_wr_q;
`else
    assign accept = write_cyc;
`endif

    // D0 enters at the top and everything moves one place toward bit 0.
    // On the last write this vector is the complete register value.
    assign shift_in = {CPU_D0, shift_q};

    always_ff @(negedge CPU_M2 or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= EMPTY;
            shift_q <= '0;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            rst_q   <= 1'b0;
            sel_q   <= 2'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            rst_q   <= rst_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        rst_d   = 1'b0;
        sel_d   = sel_q;
        data_d  = data_q;

        if (accept) begin
            if (CPU_D7) begin
                // D7 has priority over completion, even on the would-be last write.
                state_d = EMPTY;
                shift_d = '0;
                cnt_d   = 3'd0;
                rst_d   = 1'b1;
            end else if (state_q == FILLING && cnt_q == LAST_CNT) begin
                state_d = EMPTY;
                shift_d = '0;
                cnt_d   = 3'd0;
                we_d    = 1'b1;
                sel_d   = {CPU_A14, CPU_A13};
                data_d  = shift_in;
            end else begin
                state_d = FILLING;
                shift_d = shift_in[SHIFT_LEN-1:1];
                cnt_d   = cnt_q + 3'd1;
            end
        end
    end

    assign REG_WE    = we_q;
    assign LOAD_RST  = rst_q;
    assign REG_SEL   = sel_q;
    assign REG_DATA  = data_q;
    assign SHIFT_CNT = cnt_q;

endmodule
